// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing one 4:1 mux datapath.
// Registered one-hot grant and mux select, with an optional hold-time limit against starvation.
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] rel,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy
);

    typedef enum logic {IDLE, OWN} state_t;

    localparam logic [CNT_W-1:0] HOLD_LIM = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] HOLD_SAT = '1;

    state_t           state_q, state_d;
    logic [1:0]       last_q, last_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] hold_q, hold_d;

    logic       do_arb;
    logic [1:0] arb_ptr;
    logic [3:0] owner_oh;
    logic       timeout;
    logic [2:0] pick;

    // Returns {found, index}; candidates are scanned ptr+1, ptr+2, ptr+3, ptr so the
    // loop runs backwards and the earliest candidate in search order wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = '0;
        for (int k = 4; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        sel_d    = sel_q;
        gnt_d    = gnt_q;
        busy_d   = busy_q;
        hold_d   = (hold_q == HOLD_SAT) ? hold_q : hold_q + CNT_W'(1);
        do_arb   = 1'b0;
        arb_ptr  = last_q;
        owner_oh = 4'b0001 << sel_q;
        timeout  = (MAX_HOLD != 0) && (hold_q == HOLD_LIM) && (|(req & ~owner_oh));

        case (state_q)
            IDLE: begin
                do_arb  = 1'b1;
                arb_ptr = last_q;
            end
            OWN: begin
                if (rel[sel_q] || !req[sel_q] || timeout) begin
                    do_arb  = 1'b1;
                    arb_ptr = sel_q;
                    last_d  = sel_q;
                end
            end
            default: ;
        endcase

        pick = rr_pick(req, arb_ptr);

        // Re-arbitration happens on the releasing edge itself, so owners hand over without a bubble.
        if (do_arb) begin
            hold_d = '0;
            if (pick[2]) begin
                state_d = OWN;
                sel_d   = pick[1:0];
                gnt_d   = 4'b0001 << pick[1:0];
                busy_d  = 1'b1;
            end else begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 2'd3;
            sel_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            busy_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed vector table, hand sequences for rotation/timeout/lone
// requester, and randomized traffic against a behavioural round-robin model.
module tb_mux4_rr_arbiter;

    localparam int MAX_HOLD = 4;
    localparam int CNT_W    = 3;
    localparam int HOLD_MAX = (1 << CNT_W) - 1;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] rel;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: owner index (-1 when idle), pointer, select, hold cycles.
    int m_owner;
    int m_last;
    int m_sel;
    int m_hold;

    typedef struct {
        logic       rs;
        logic [3:0] r;
        logic [3:0] l;
        logic [3:0] g;
        logic [1:0] s;
        logic       b;
    } vec_t;

    vec_t vecs[17];

    mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .rel  (rel),
        .gnt  (gnt),
        .sel  (sel),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int search(input logic [3:0] r, input int from);
        for (int k = 1; k <= 4; k++) begin
            if (r[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step(input logic rs, input logic [3:0] r, input logic [3:0] l);
        int  w;
        bit  others;
        bit  release_now;
        if (rs) begin
            m_owner = -1; m_last = 3; m_sel = 0; m_hold = 0;
        end else if (m_owner < 0) begin
            w = search(r, m_last);
            if (w >= 0) begin m_owner = w; m_sel = w; end
            m_hold = 0;
        end else begin
            others = 0;
            for (int j = 0; j < 4; j++) if (j != m_owner && r[j]) others = 1;
            release_now = l[m_owner] || !r[m_owner] ||
                          (MAX_HOLD != 0 && m_hold == MAX_HOLD - 1 && others);
            if (release_now) begin
                m_last = m_owner;
                w = search(r, m_last);
                m_owner = w;
                if (w >= 0) m_sel = w;
                m_hold = 0;
            end else if (m_hold < HOLD_MAX) begin
                m_hold = m_hold + 1;
            end
        end
    endtask

    task automatic cycle(input logic rs, input logic [3:0] r, input logic [3:0] l);
        rst = rs; req = r; rel = l;
        @(posedge clk);
        model_step(rs, r, l);
        #1;
    endtask

    task automatic chk(input string nm, input logic [3:0] g, input logic [1:0] s, input logic b);
        checks++;
        if (gnt !== g || sel !== s || busy !== b) begin
            errors++;
            $display("FAIL %s: got gnt=%b sel=%0d busy=%b, want gnt=%b sel=%0d busy=%b",
                     nm, gnt, sel, busy, g, s, b);
        end
        checks++;
        if ($countones(gnt) > 1 || busy !== (|gnt) || (busy && gnt !== (4'b0001 << sel))) begin
            errors++;
            $display("FAIL %s invariant: gnt=%b sel=%0d busy=%b", nm, gnt, sel, busy);
        end
    endtask

    task automatic chk_model(input string nm);
        logic [3:0] g;
        g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        chk(nm, g, 2'(m_sel), m_owner >= 0);
    endtask

    initial begin
        logic [3:0] exp_g;
        logic [3:0] rr;
        logic [3:0] rl;
        logic       rs;

        rst = 1'b1; req = '0; rel = '0;
        m_owner = -1; m_last = 3; m_sel = 0; m_hold = 0;

        //           rs    req      rel      gnt      sel   busy
        vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};
        vecs[1]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};
        vecs[2]  = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1};
        vecs[3]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};
        vecs[4]  = '{1'b0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1};
        vecs[5]  = '{1'b0, 4'b1010, 4'b0001, 4'b0010, 2'd1, 1'b1};
        vecs[6]  = '{1'b0, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1};
        vecs[7]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1};
        vecs[8]  = '{1'b1, 4'b0100, 4'b0000, 4'b0000, 2'd0, 1'b0};
        vecs[9]  = '{1'b0, 4'b1001, 4'b0000, 4'b0001, 2'd0, 1'b1};
        vecs[10] = '{1'b0, 4'b1001, 4'b0001, 4'b1000, 2'd3, 1'b1};
        vecs[11] = '{1'b0, 4'b1001, 4'b0000, 4'b1000, 2'd3, 1'b1};
        vecs[12] = '{1'b0, 4'b1001, 4'b1000, 4'b0001, 2'd0, 1'b1};
        vecs[13] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};
        vecs[14] = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1};
        vecs[15] = '{1'b0, 4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1};
        vecs[16] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};

        for (int i = 0; i < 17; i++) begin
            cycle(vecs[i].rs, vecs[i].r, vecs[i].l);
            chk($sformatf("vec%0d", i), vecs[i].g, vecs[i].s, vecs[i].b);
        end

        // Rotation: all request, owner releases on the second cycle of its grant.
        cycle(1'b1, 4'b0000, 4'b0000);
        cycle(1'b0, 4'b1111, 4'b0000);
        chk("rot_first", 4'b0001, 2'd0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            exp_g = 4'b0001 << k;
            cycle(1'b0, 4'b1111, 4'b0000);
            chk($sformatf("rot_hold%0d", k), exp_g, 2'(k), 1'b1);
            cycle(1'b0, 4'b1111, exp_g);
            chk($sformatf("rot_next%0d", k), 4'b0001 << ((k + 1) % 4), 2'((k + 1) % 4), 1'b1);
        end

        // Timeout: two requesters alternate every MAX_HOLD cycles.
        cycle(1'b1, 4'b0000, 4'b0000);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 4'b0011, 4'b0000);
            if (((i / MAX_HOLD) % 2) == 0) chk($sformatf("tmo%0d", i), 4'b0001, 2'd0, 1'b1);
            else                           chk($sformatf("tmo%0d", i), 4'b0010, 2'd1, 1'b1);
        end

        // Lone requester keeps the grant well past the hold limit and counter saturation.
        cycle(1'b1, 4'b0000, 4'b0000);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 4'b0100, 4'b0000);
            chk($sformatf("lone%0d", i), 4'b0100, 2'd2, 1'b1);
        end

        // Randomized traffic against the model.
        cycle(1'b1, 4'b0000, 4'b0000);
        chk_model("rnd_rst");
        rr = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) rr = rr ^ 4'($urandom_range(1, 15));
            rl = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            rs = ($urandom_range(0, 199) == 0);
            cycle(rs, rr, rl);
            chk_model($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 mux datapath among four requesters.
- Grants exactly one requester at a time.
- Drives the mux 2-bit select with the winner's index.
- Enforces a maximum hold time so no requester starves the others.
- Sits directly in front of the mux: sel connects to the mux select; requester blocks use gnt/rel as their handshake.

Parameters:
- MAX_HOLD, 16: maximum consecutive grant cycles while another requester waits; 0 disables the timeout.
- CNT_W, 5: hold counter width; must satisfy 2^CNT_W >= MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  4  request per requester, level; bit i = requester i.
- rel  input  4  release pulse per requester; only the current owner's bit has effect.
- gnt  output 4  one-hot grant, registered; all zero when idle.
- sel  output 2  index of the current owner, to the mux select; registered.
- busy output 1  high while any grant is active.

Behaviour:
- Reset (rst=1 at a clk edge, overrides all else):
  - gnt=0000, sel=00, busy=0.
  - State=IDLE, hold_cnt=0.
  - Priority pointer last=3, so requester 0 wins first.
- All outputs are registered; no combinational path from req/rel to gnt/sel.
- Search order: starting after last, wrap modulo 4: last+1, last+2, last+3, last. The first index with req set wins.
- IDLE state:
  - If any req bit is set at an edge, at that same edge: gnt=onehot(winner), sel=winner, busy=1, hold_cnt=0, state->OWN.
  - Latency: req sampled high at edge N gives gnt high after edge N.
  - If no req is set, stay in IDLE; gnt=0 and busy=0; sel holds its previous value.
- OWN state, owner o. hold_cnt increments each cycle and saturates at 2^CNT_W-1. Release occurs at an edge when any of the following holds:
  - (a) rel[o]=1;
  - (b) req[o]=0;
  - (c) MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, and (req & ~onehot(o))!=0.
- On release:
  - last=o.
  - Re-arbitrate in the same edge using the search order above. There is no idle bubble between owners.
  - A new winner gets gnt/sel updated and hold_cnt=0.
  - If no req is set: state->IDLE, gnt=0000, busy=0, sel unchanged.
  - The owner can win again only if no other requester is asserting req, because it is last in the search order. After timeout (c) another requester is guaranteed to win.
  - Re-grant to the same owner resets hold_cnt to 0.
- Timeout with a lone requester: (c) never fires; the owner keeps the grant indefinitely.
- rel bits of non-owners are ignored. rel in IDLE is ignored.
- Owner's req and rel both high in the same cycle: treated as a release; the owner is re-granted only if no other requester is waiting.
- Invariants, checked every cycle:
  - popcount(gnt) <= 1.
  - busy == |gnt.
  - When busy=1: gnt == onehot(sel) and req[sel] was high at the granting edge.
- Reset mid-grant: gnt drops at that edge; no release bookkeeping; pointer returns to 3.

Test Plan:
1. Basic grant: rst for 2 cycles, then req=0001.
   - One edge later: gnt=0001, sel=0, busy=1.
   - Drop req: after the next edge gnt=0000, busy=0, sel stays 0.
2. Rotation: req=1111 held; owner pulses rel 2 cycles after each grant.
   - Grant sequence 0001, 0010, 0100, 1000, 0001, each switch back-to-back with no zero-gnt cycle.
3. Timeout (MAX_HOLD=4): req=0011 held, no rel.
   - gnt=0001 for exactly 4 cycles, then 0010 for 4, then 0001; pattern repeats.
4. Lone requester (MAX_HOLD=4): req=0100 held for 20 cycles.
   - gnt=0100, sel=2 for all 20 cycles; busy never drops.
5. Handover and ignored release:
   - Owner 1 drops req while req[3]=1: next edge gnt=1000, sel=3.
   - rel=0001 pulsed meanwhile (non-owner): no effect.
6. Reset mid-operation:
   - While gnt=0100, assert rst: next edge gnt=0000, busy=0, sel=00.
   - Release rst with req=1001 simultaneously: gnt=0001 (pointer reset to 3).
   - Then rel[0] pulse: gnt=1000.
